// File: rtl/dm_cache_ctrl_pkg.sv
// Shared definitions for the direct-mapped write-through cache controller:
// bus widths, processor request codes and controller state encoding.
package dm_cache_ctrl_pkg;

  localparam int ADDRWIDTH    = 8;
  localparam int WORDWIDTH    = 16;
  localparam int IOSTATEWIDTH = 2;
  localparam int CSTATEWIDTH  = 2;
  localparam int DEF_INDEXW   = 3;

  localparam logic [IOSTATEWIDTH-1:0] IO_IDEL = 2'd0;
  localparam logic [IOSTATEWIDTH-1:0] IO_RD   = 2'd1;
  localparam logic [IOSTATEWIDTH-1:0] IO_WT   = 2'd2;

  typedef enum logic [CSTATEWIDTH-1:0] {
    C_IDLE   = 2'd0,
    C_RDMISS = 2'd1,
    C_WRITE  = 2'd2,
    C_RESP   = 2'd3
  } cstate_e;

endpackage

// File: rtl/dm_cache_ctrl_cache_line_array.sv
// Valid/tag/data storage for the direct-mapped cache: combinational read by
// index, a single write port, and an asynchronous clear of the valid bits.
module dm_cache_ctrl_cache_line_array
  import dm_cache_ctrl_pkg::*;
#(
  parameter int INDEXW = DEF_INDEXW,
  parameter int TAGW   = ADDRWIDTH - INDEXW,
  parameter int WORDW  = WORDWIDTH
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [INDEXW-1:0] rdIdx_i,
  output logic              rdValid_o,
  output logic [TAGW-1:0]   rdTag_o,
  output logic [WORDW-1:0]  rdData_o,
  input  logic              we_i,
  input  logic [INDEXW-1:0] wrIdx_i,
  input  logic [TAGW-1:0]   wrTag_i,
  input  logic [WORDW-1:0]  wrData_i
);

  localparam int LINES = 1 << INDEXW;

  logic [LINES-1:0] valid_q;
  logic [TAGW-1:0]  tag_q  [LINES];
  logic [WORDW-1:0] data_q [LINES];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
    end else if (we_i) begin
      valid_q[wrIdx_i] <= 1'b1;
    end
  end

  // Tag and data are meaningless until their valid bit is set, so they carry no reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      tag_q[wrIdx_i]  <= wrTag_i;
      data_q[wrIdx_i] <= wrData_i;
    end
  end

  assign rdValid_o = valid_q[rdIdx_i];
  assign rdTag_o   = tag_q[rdIdx_i];
  assign rdData_o  = data_q[rdIdx_i];

endmodule

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache controller between a
// processor port and main memory, with saturating read hit/miss counters.
module dm_cache_ctrl
  import dm_cache_ctrl_pkg::*;
#(
  parameter int INDEXW = DEF_INDEXW,
  parameter int CNTW   = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [IOSTATEWIDTH-1:0] rwToMem,
  input  logic [ADDRWIDTH-1:0]    addrToMem,
  input  logic [WORDWIDTH-1:0]    dataToMem,
  output logic                    cacheEn,
  output logic [WORDWIDTH-1:0]    dataFromMem,
  output logic                    memReq,
  output logic                    memWe,
  output logic [ADDRWIDTH-1:0]    memAddr,
  output logic [WORDWIDTH-1:0]    memWData,
  input  logic [WORDWIDTH-1:0]    memRData,
  input  logic                    memAck,
  output logic [CNTW-1:0]         hitCount,
  output logic [CNTW-1:0]         missCount
);

  localparam int TAGW = ADDRWIDTH - INDEXW;

  cstate_e                state_q, state_d;
  logic                   cacheEn_q, cacheEn_d;
  logic [WORDWIDTH-1:0]   dataFromMem_q, dataFromMem_d;
  logic                   memReq_q, memReq_d;
  logic                   memWe_q, memWe_d;
  logic [ADDRWIDTH-1:0]   memAddr_q, memAddr_d;
  logic [WORDWIDTH-1:0]   memWData_q, memWData_d;
  logic [CNTW-1:0]        hitCount_q, hitCount_d;
  logic [CNTW-1:0]        missCount_q, missCount_d;

  logic [INDEXW-1:0]      rdIdx;
  logic [TAGW-1:0]        reqTag;
  logic                   rdValid;
  logic [TAGW-1:0]        rdTag;
  logic [WORDWIDTH-1:0]   rdData;
  logic                   lineHit;
  logic                   arrWe;
  logic [WORDWIDTH-1:0]   arrData;

  // Idle looks up the live request; the wait states look up the captured address.
  assign rdIdx   = (state_q == C_IDLE) ? addrToMem[INDEXW-1:0] : memAddr_q[INDEXW-1:0];
  assign reqTag  = (state_q == C_IDLE) ? addrToMem[ADDRWIDTH-1:INDEXW]
                                       : memAddr_q[ADDRWIDTH-1:INDEXW];
  assign lineHit = rdValid && (rdTag == reqTag);

  dm_cache_ctrl_cache_line_array #(
    .INDEXW (INDEXW),
    .TAGW   (TAGW),
    .WORDW  (WORDWIDTH)
  ) u_lines (
    .clk_i     (clk),
    .rst_ni    (reset),
    .rdIdx_i   (rdIdx),
    .rdValid_o (rdValid),
    .rdTag_o   (rdTag),
    .rdData_o  (rdData),
    .we_i      (arrWe),
    .wrIdx_i   (memAddr_q[INDEXW-1:0]),
    .wrTag_i   (memAddr_q[ADDRWIDTH-1:INDEXW]),
    .wrData_i  (arrData)
  );

  always_comb begin
    state_d       = state_q;
    cacheEn_d     = cacheEn_q;
    dataFromMem_d = dataFromMem_q;
    memReq_d      = memReq_q;
    memWe_d       = memWe_q;
    memAddr_d     = memAddr_q;
    memWData_d    = memWData_q;
    hitCount_d    = hitCount_q;
    missCount_d   = missCount_q;
    arrWe         = 1'b0;
    arrData       = memRData;

    unique case (state_q)
      C_IDLE: begin
        if (rwToMem == IO_RD) begin
          if (lineHit) begin
            cacheEn_d     = 1'b1;
            dataFromMem_d = rdData;
            hitCount_d    = (hitCount_q == '1) ? hitCount_q : hitCount_q + CNTW'(1);
            state_d       = C_RESP;
          end else begin
            missCount_d = (missCount_q == '1) ? missCount_q : missCount_q + CNTW'(1);
            memReq_d    = 1'b1;
            memWe_d     = 1'b0;
            memAddr_d   = addrToMem;
            state_d     = C_RDMISS;
          end
        end else if (rwToMem == IO_WT) begin
          memReq_d   = 1'b1;
          memWe_d    = 1'b1;
          memAddr_d  = addrToMem;
          memWData_d = dataToMem;
          state_d    = C_WRITE;
        end
      end
      C_RDMISS: begin
        if (memAck) begin
          arrWe         = 1'b1;
          memReq_d      = 1'b0;
          cacheEn_d     = 1'b1;
          dataFromMem_d = memRData;
          state_d       = C_RESP;
        end
      end
      C_WRITE: begin
        // Write-through without allocation: only a line already holding this address changes.
        if (memAck) begin
          arrWe     = lineHit;
          arrData   = memWData_q;
          memReq_d  = 1'b0;
          memWe_d   = 1'b0;
          cacheEn_d = 1'b1;
          state_d   = C_RESP;
        end
      end
      C_RESP: begin
        cacheEn_d = 1'b0;
        state_d   = C_IDLE;
      end
      default: state_d = C_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= C_IDLE;
      cacheEn_q     <= 1'b0;
      dataFromMem_q <= '0;
      memReq_q      <= 1'b0;
      memWe_q       <= 1'b0;
      memAddr_q     <= '0;
      memWData_q    <= '0;
      hitCount_q    <= '0;
      missCount_q   <= '0;
    end else begin
      state_q       <= state_d;
      cacheEn_q     <= cacheEn_d;
      dataFromMem_q <= dataFromMem_d;
      memReq_q      <= memReq_d;
      memWe_q       <= memWe_d;
      memAddr_q     <= memAddr_d;
      memWData_q    <= memWData_d;
      hitCount_q    <= hitCount_d;
      missCount_q   <= missCount_d;
    end
  end

  assign cacheEn     = cacheEn_q;
  assign dataFromMem = dataFromMem_q;
  assign memReq      = memReq_q;
  assign memWe       = memWe_q;
  assign memAddr     = memAddr_q;
  assign memWData    = memWData_q;
  assign hitCount    = hitCount_q;
  assign missCount   = missCount_q;

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Self-checking bench for dm_cache_ctrl: a line-level cache model plus a
// latency-programmable memory responder, checked against the DUT every cycle.
module tb_dm_cache_ctrl;
  import dm_cache_ctrl_pkg::*;

  localparam int CNTW   = 3;
  localparam int CNTMAX = (1 << CNTW) - 1;

  logic                 clk;
  logic                 reset;
  logic [1:0]           rwToMem;
  logic [7:0]           addrToMem;
  logic [15:0]          dataToMem;
  logic                 cacheEn;
  logic [15:0]          dataFromMem;
  logic                 memReq;
  logic                 memWe;
  logic [7:0]           memAddr;
  logic [15:0]          memWData;
  logic [15:0]          memRData;
  logic                 memAck;
  logic [CNTW-1:0]      hitCount;
  logic [CNTW-1:0]      missCount;

  int checks = 0;
  int errors = 0;

  // Model state: line contents and the outputs the DUT must currently show.
  bit          mValid [8];
  logic [4:0]  mTag   [8];
  logic [15:0] mData  [8];
  logic        expCacheEn, expMemReq, expWe;
  logic [7:0]  expAddr;
  logic [15:0] expWData, expData;
  int          expHit, expMiss;

  logic [15:0] memArr [256];
  int          ackDelay;
  int          reqCycles = 0;
  int          cacheEnPulses = 0;
  logic [15:0] lastData = '0;
  int          reqBase, pulseBase;

  dm_cache_ctrl #(.INDEXW(3), .CNTW(CNTW)) dut (
    .clk         (clk),
    .reset       (reset),
    .rwToMem     (rwToMem),
    .addrToMem   (addrToMem),
    .dataToMem   (dataToMem),
    .cacheEn     (cacheEn),
    .dataFromMem (dataFromMem),
    .memReq      (memReq),
    .memWe       (memWe),
    .memAddr     (memAddr),
    .memWData    (memWData),
    .memRData    (memRData),
    .memAck      (memAck),
    .hitCount    (hitCount),
    .missCount   (missCount)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, actual, required, $time);
    end
  endtask

  function automatic int satInc(input int v);
    return (v >= CNTMAX) ? CNTMAX : v + 1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic resetModel();
    for (int i = 0; i < 8; i++) mValid[i] = 1'b0;
    expCacheEn = 1'b0;
    expMemReq  = 1'b0;
    expWe      = 1'b0;
    expAddr    = '0;
    expWData   = '0;
    expData    = '0;
    expHit     = 0;
    expMiss    = 0;
  endtask

  // Memory: acknowledges ackDelay cycles after first seeing a request.
  initial begin
    int cnt;
    cnt = 0;
    memAck = 1'b0;
    memRData = '0;
    for (int i = 0; i < 256; i++) memArr[i] = 16'h1000 + 16'(i);
    memArr[8'h05] = 16'h00AB;
    memArr[8'h0D] = 16'h0077;
    forever begin
      @(posedge clk);
      #1;
      memAck = 1'b0;
      if (memReq === 1'b1) begin
        if (cnt == ackDelay) begin
          memAck   = 1'b1;
          memRData = memArr[memAddr];
          if (memWe) memArr[memAddr] = memWData;
          cnt = 0;
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (memReq) reqCycles++;
    if (cacheEn) begin
      cacheEnPulses++;
      lastData = dataFromMem;
    end
    checkOutput("cacheEn", 32'(cacheEn), 32'(expCacheEn));
    checkOutput("memReq", 32'(memReq), 32'(expMemReq));
    checkOutput("memWe", 32'(memWe), 32'(expWe));
    checkOutput("memAddr", 32'(memAddr), 32'(expAddr));
    checkOutput("memWData", 32'(memWData), 32'(expWData));
    checkOutput("hitCount", 32'(hitCount), 32'(expHit));
    checkOutput("missCount", 32'(missCount), 32'(expMiss));
    if (expCacheEn) checkOutput("dataFromMem", 32'(dataFromMem), 32'(expData));
  end

  // One processor access, held until the response, with the model updated alongside.
  task automatic applyStimulus(input logic [1:0] rw, input logic [7:0] addr,
                               input logic [15:0] wdata, input int n);
    int idx;
    logic [4:0] tag;
    bit hit;
    idx = int'(addr[2:0]);
    tag = addr[7:3];
    hit = mValid[idx] && (mTag[idx] == tag);
    ackDelay  = n;
    reqBase   = reqCycles;
    pulseBase = cacheEnPulses;
    rwToMem   = rw;
    addrToMem = addr;
    dataToMem = wdata;
    step();
    if (rw == IO_RD && hit) begin
      expCacheEn = 1'b1;
      expData    = mData[idx];
      expHit     = satInc(expHit);
      step();
    end else begin
      if (rw == IO_RD) begin
        expMiss = satInc(expMiss);
        expWe   = 1'b0;
      end else begin
        expWe    = 1'b1;
        expWData = wdata;
      end
      expMemReq = 1'b1;
      expAddr   = addr;
      addrToMem = ~addr;
      dataToMem = ~wdata;
      repeat (n + 1) step();
      expMemReq  = 1'b0;
      expWe      = 1'b0;
      expCacheEn = 1'b1;
      if (rw == IO_RD) begin
        expData     = memArr[addr];
        mValid[idx] = 1'b1;
        mTag[idx]   = tag;
        mData[idx]  = memArr[addr];
      end else if (hit) begin
        mData[idx] = wdata;
      end
      step();
    end
    expCacheEn = 1'b0;
    rwToMem    = IO_IDEL;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL timeout reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    reset     = 1'b0;
    rwToMem   = IO_IDEL;
    addrToMem = '0;
    dataToMem = '0;
    ackDelay  = 0;
    resetModel();
    repeat (2) step();
    reset = 1'b1;
    step();
    checkOutput("rstCacheEn", 32'(cacheEn), 32'd0);
    checkOutput("rstMemReq", 32'(memReq), 32'd0);
    checkOutput("rstDataFromMem", 32'(dataFromMem), 32'd0);
    checkOutput("rstMissCount", 32'(missCount), 32'd0);

    rwToMem = 2'b11;
    addrToMem = 8'h05;
    reqBase = reqCycles;
    repeat (3) step();
    rwToMem = IO_IDEL;
    checkOutput("undefCodeIgnored", 32'(reqCycles - reqBase), 32'd0);

    applyStimulus(IO_RD, 8'h05, 16'h0, 3);
    checkOutput("t1ReqCycles", 32'(reqCycles - reqBase), 32'd4);
    checkOutput("t1Pulses", 32'(cacheEnPulses - pulseBase), 32'd1);
    checkOutput("t1Data", 32'(lastData), 32'h00AB);
    checkOutput("t1MissCount", 32'(missCount), 32'd1);

    applyStimulus(IO_RD, 8'h05, 16'h0, 3);
    checkOutput("t2ReqCycles", 32'(reqCycles - reqBase), 32'd0);
    checkOutput("t2Data", 32'(lastData), 32'h00AB);
    checkOutput("t2HitCount", 32'(hitCount), 32'd1);

    applyStimulus(IO_WT, 8'h05, 16'h003C, 1);
    checkOutput("t3WrReqCycles", 32'(reqCycles - reqBase), 32'd2);
    applyStimulus(IO_RD, 8'h05, 16'h0, 1);
    checkOutput("t3Data", 32'(lastData), 32'h003C);
    checkOutput("t3HitCount", 32'(hitCount), 32'd2);

    applyStimulus(IO_RD, 8'h0D, 16'h0, 0);
    checkOutput("t4ConflictData", 32'(lastData), 32'h0077);
    checkOutput("t4MinLatency", 32'(reqCycles - reqBase), 32'd1);
    applyStimulus(IO_RD, 8'h05, 16'h0, 2);
    checkOutput("t4Refill", 32'(lastData), 32'h003C);
    checkOutput("t4MissCount", 32'(missCount), 32'd3);

    applyStimulus(IO_WT, 8'h11, 16'h0099, 2);
    applyStimulus(IO_RD, 8'h11, 16'h0, 1);
    checkOutput("t5NoAllocReq", 32'(reqCycles - reqBase), 32'd2);
    checkOutput("t5Data", 32'(lastData), 32'h0099);
    checkOutput("t5MissCount", 32'(missCount), 32'd4);

    for (int i = 0; i < 6; i++) applyStimulus(IO_RD, 8'h11, 16'h0, 0);
    checkOutput("satHitCount", 32'(hitCount), 32'd7);

    ackDelay  = 5;
    rwToMem   = IO_RD;
    addrToMem = 8'h15;
    step();
    expMiss   = satInc(expMiss);
    expMemReq = 1'b1;
    expWe     = 1'b0;
    expAddr   = 8'h15;
    step();
    #2;
    reset = 1'b0;
    resetModel();
    #1;
    checkOutput("t6MemReqAsync", 32'(memReq), 32'd0);
    checkOutput("t6CacheEnAsync", 32'(cacheEn), 32'd0);
    checkOutput("t6HitCount", 32'(hitCount), 32'd0);
    checkOutput("t6MissCount", 32'(missCount), 32'd0);
    rwToMem = IO_IDEL;
    repeat (2) step();
    reset = 1'b1;
    step();
    applyStimulus(IO_RD, 8'h05, 16'h0, 3);
    checkOutput("t6MissAfterReset", 32'(missCount), 32'd1);
    checkOutput("t6Data", 32'(lastData), 32'h003C);
    checkOutput("t6ReqCycles", 32'(reqCycles - reqBase), 32'd4);

    repeat (2) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
